chan_pkt_tx: RTL

Command-driven packet transmitter that drives the transmit side of the team's packet channel (data/valid/ready/sop/eop/empty/almost_full/channel). Each accepted command emits one packet of a given byte length on a given channel, filled with a deterministic byte pattern. It is used as a traffic source in front of any channel receiver in the RTL simulation environment, and as a loopback stimulus generator.

---
 rtl/chan_pkt_tx_if.sv | 32 +++
 rtl/chan_pkt_tx.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/chan_pkt_tx_if.sv
// chan_pkt_tx_if
// Transmit side of the packet channel. The transmitter owns data, valid,
// sop, eop, empty and channel. The receiver owns ready and almost_full.
//   data        : packet word, byte 0 in the most significant byte
//   valid/ready : word handshake, a transfer happens when both are high
//   sop/eop     : first / last word of a packet
//   empty       : unused trailing bytes in the eop word
//   almost_full : receiver hint that holds off the start of a packet
//   channel     : channel tag for the whole packet
interface chan_pkt_tx_if #(
    parameter int WIDTH = 512,
    parameter int NUM   = 2
);
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             ready;
    logic             sop;
    logic             eop;
    logic [5:0]       empty;
    logic             almost_full;
    logic [NUM-1:0]   channel;

    modport master (
        output data, valid, sop, eop, empty, channel,
        input  ready, almost_full
    );

    modport slave (
        input  data, valid, sop, eop, empty, channel,
        output ready, almost_full
    );
endinterface

// File: rtl/chan_pkt_tx.sv
// chan_pkt_tx
// Command-driven packet transmitter. Each accepted command produces one
// packet of cmd_len bytes on cmd_channel. Byte k of the packet is
// (cmd_seed + k) mod 256, and any padding bytes in the last word are zero.
// A zero-length command produces no packet and is only counted.
//   clk, rst_n      : clock, asynchronous active-low reset
//   cmd_valid/ready : command handshake
//   cmd_len         : packet length in bytes
//   cmd_channel     : channel tag for the packet
//   cmd_seed        : payload pattern seed
//   tx              : packet channel, transmitter side
//   pkt_cnt         : packets whose eop word has transferred (wraps)
//   drop_cnt        : zero-length commands discarded (saturates)
module chan_pkt_tx #(
    parameter int WIDTH = 512,
    parameter int NUM   = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [15:0]         cmd_len,
    input  logic [NUM-1:0]      cmd_channel,
    input  logic [7:0]          cmd_seed,
    chan_pkt_tx_if.master       tx,
    output logic [31:0]         pkt_cnt,
    output logic [15:0]         drop_cnt
);

    localparam int BYTES = WIDTH / 8;
    localparam int SHIFT = $clog2(BYTES);
    localparam logic [15:0] BMASK = 16'(BYTES - 1);

    typedef enum logic [1:0] {IDLE, ARM, SEND} state_t;

    state_t           state;
    state_t           state_next;

    logic [15:0]      len_q;
    logic [NUM-1:0]   chan_q;
    logic [7:0]       seed_q;
    logic [16:0]      words_left;
    logic [16:0]      byte_off;

    logic             do_latch;
    logic             do_drop;
    logic             do_first;
    logic             do_next;
    logic             do_finish;

    logic [WIDTH-1:0] word_next;
    logic             last_word;
    logic [15:0]      len_mod;
    logic [5:0]       empty_last;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. ARM waits for the receiver to drop almost_full.
    // Once in SEND, almost_full is ignored so a started packet always completes.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cmd_valid && cmd_len != 16'd0) state_next = ARM;
            ARM:     if (!tx.almost_full) state_next = SEND;
            SEND:    if (tx.valid && tx.ready && tx.eop) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode into one-cycle strobes for the datapath. A non-eop
    // transfer loads the next word on the same edge, so a packet streams
    // with no bubbles while ready stays high.
    always_comb begin
        do_latch  = 1'b0;
        do_drop   = 1'b0;
        do_first  = 1'b0;
        do_next   = 1'b0;
        do_finish = 1'b0;
        case (state)
            IDLE: begin
                do_latch = cmd_valid && (cmd_len != 16'd0);
                do_drop  = cmd_valid && (cmd_len == 16'd0);
            end
            ARM: begin
                do_first = !tx.almost_full;
            end
            SEND: begin
                do_next   = tx.valid && tx.ready && !tx.eop;
                do_finish = tx.valid && tx.ready && tx.eop;
            end
            default: ;
        endcase
    end

    // Build the word that starts at byte_off. BYTES divides 256, so the low
    // byte of the offset is enough to form seed + k. Positions at or past
    // the packet length are zero padding.
    always_comb begin
        word_next = '0;
        for (int j = 0; j < BYTES; j++) begin
            if ((byte_off + 17'(j)) < {1'b0, len_q}) begin
                word_next[WIDTH-1-8*j -: 8] = seed_q + byte_off[7:0] + 8'(j);
            end
        end
    end

    // The word being loaded is the last one when exactly one word remains.
    // Its empty count is the byte shortfall against a full word. This is
    // zero when the length is a multiple of BYTES.
    assign last_word  = (words_left == 17'd1);
    assign len_mod    = len_q & BMASK;
    assign empty_last = 6'((17'(BYTES) - {1'b0, len_mod}) & {1'b0, BMASK});

    // Datapath and registered outputs. cmd_ready is registered from the
    // next state, so it is high exactly while the FSM sits in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_ready  <= 1'b1;
            len_q      <= '0;
            chan_q     <= '0;
            seed_q     <= '0;
            words_left <= '0;
            byte_off   <= '0;
            tx.data    <= '0;
            tx.valid   <= 1'b0;
            tx.sop     <= 1'b0;
            tx.eop     <= 1'b0;
            tx.empty   <= '0;
            tx.channel <= '0;
            pkt_cnt    <= '0;
            drop_cnt   <= '0;
        end else begin
            cmd_ready <= (state_next == IDLE);

            if (do_latch) begin
                len_q      <= cmd_len;
                chan_q     <= cmd_channel;
                seed_q     <= cmd_seed;
                words_left <= (17'(cmd_len) + 17'(BYTES - 1)) >> SHIFT;
                byte_off   <= '0;
            end

            if (do_drop && drop_cnt != 16'hFFFF) begin
                drop_cnt <= drop_cnt + 16'd1;
            end

            if (do_first || do_next) begin
                tx.data    <= word_next;
                tx.valid   <= 1'b1;
                tx.sop     <= do_first;
                tx.eop     <= last_word;
                tx.empty   <= last_word ? empty_last : 6'd0;
                tx.channel <= chan_q;
                words_left <= words_left - 17'd1;
                byte_off   <= byte_off + 17'(BYTES);
            end

            if (do_finish) begin
                tx.valid <= 1'b0;
                tx.sop   <= 1'b0;
                tx.eop   <= 1'b0;
                tx.empty <= '0;
                pkt_cnt  <= pkt_cnt + 32'd1;
            end
        end
    end

endmodule
